fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline. Owns the PC register, drives the I-cache request
//  and holds the IF/ID pipeline register. Opcode_o/Funct_o feed the ID-stage decoder.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: FSM state encoding and the default bubble word.
// Imported by the fetch stage, its IF/ID register and anything else that decodes IF state.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IF_ST_IDLE       = 2'd0,
    IF_ST_FETCH      = 2'd1,
    IF_ST_MISS       = 2'd2,
    IF_ST_MISS_REDIR = 2'd3
  } if_state_e;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush and load controls.
// Holding is the default; a flush inserts a bubble but keeps PCPlus4.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;
  logic        r_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instr   <= NOP_INSTR;
      r_pcplus4 <= 32'd0;
      r_valid   <= 1'b0;
    end else if (flush_i) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_instr   <= instr_i;
      r_pcplus4 <= pcplus4_i;
      r_valid   <= 1'b1;
    end
  end

  assign instr_o   = r_instr;
  assign pcplus4_o = r_pcplus4;
  assign valid_o   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, I-cache request FSM and pending-redirect register.
// The IF/ID register lives in if_id_reg and is driven by load/flush strobes from here.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        ICacheReq_o,
  output logic [31:0] ICacheAddr_o,
  input  logic [31:0] ICacheRdata_i,
  input  logic        ICacheStall_i,
  input  logic        Stall_i,
  input  logic        Redirect_i,
  input  logic [31:0] RedirectPC_i,
  output logic [31:0] Instr_o,
  output logic [5:0]  Opcode_o,
  output logic [5:0]  Funct_o,
  output logic [31:0] PCPlus4_o,
  output logic        Valid_o
);

  if_state_e   r_state;
  if_state_e   w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_redir_pc;
  logic [31:0] w_redir_pc_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redir_target;
  logic        w_req;
  logic        w_load;
  logic        w_flush;

  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_redir_target = word_align(RedirectPC_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IF_ST_IDLE;
      r_pc       <= RESET_PC;
      r_redir_pc <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_redir_pc <= w_redir_pc_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_redir_pc_next = r_redir_pc;
    w_req           = 1'b0;
    w_load          = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      IF_ST_IDLE: begin
        w_state_next = IF_ST_FETCH;
      end
      IF_ST_FETCH, IF_ST_MISS: begin
        w_req = 1'b1;
        if (ICacheStall_i) begin
          // The address must stay put during a miss, so a redirect is only remembered.
          w_state_next = Redirect_i ? IF_ST_MISS_REDIR : IF_ST_MISS;
          if (Redirect_i) w_redir_pc_next = w_redir_target;
          w_flush = Redirect_i || !Stall_i;
        end else if (Redirect_i) begin
          w_state_next = IF_ST_FETCH;
          w_pc_next    = w_redir_target;
          w_flush      = 1'b1;
        end else if (Stall_i) begin
          w_state_next = IF_ST_FETCH;
        end else begin
          w_state_next = IF_ST_FETCH;
          w_pc_next    = w_pc_plus4;
          w_load       = 1'b1;
        end
      end
      IF_ST_MISS_REDIR: begin
        w_req = 1'b1;
        if (ICacheStall_i) begin
          if (Redirect_i) w_redir_pc_next = w_redir_target;
          w_flush = Redirect_i || !Stall_i;
        end else begin
          w_state_next = IF_ST_FETCH;
          w_pc_next    = Redirect_i ? w_redir_target : r_redir_pc;
          w_flush      = 1'b1;
        end
      end
      default: w_state_next = IF_ST_IDLE;
    endcase
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (w_load),
    .flush_i   (w_flush),
    .instr_i   (ICacheRdata_i),
    .pcplus4_i (w_pc_plus4),
    .instr_o   (Instr_o),
    .pcplus4_o (PCPlus4_o),
    .valid_o   (Valid_o)
  );

  assign ICacheReq_o  = w_req;
  assign ICacheAddr_o = r_pc;
  assign Opcode_o     = Instr_o[31:26];
  assign Funct_o      = Instr_o[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hits, hazard stalls, redirects, cache misses, reset and PC wrap.
// The instruction memory returns 0x1000_0000 | address so every fetched word is recognisable.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ICacheReq_o;
  logic [31:0] ICacheAddr_o;
  logic [31:0] ICacheRdata_i;
  logic        ICacheStall_i;
  logic        Stall_i;
  logic        Redirect_i;
  logic [31:0] RedirectPC_i;
  logic [31:0] Instr_o;
  logic [5:0]  Opcode_o;
  logic [5:0]  Funct_o;
  logic [31:0] PCPlus4_o;
  logic        Valid_o;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ICacheReq_o   (ICacheReq_o),
    .ICacheAddr_o  (ICacheAddr_o),
    .ICacheRdata_i (ICacheRdata_i),
    .ICacheStall_i (ICacheStall_i),
    .Stall_i       (Stall_i),
    .Redirect_i    (Redirect_i),
    .RedirectPC_i  (RedirectPC_i),
    .Instr_o       (Instr_o),
    .Opcode_o      (Opcode_o),
    .Funct_o       (Funct_o),
    .PCPlus4_o     (PCPlus4_o),
    .Valid_o       (Valid_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb ICacheRdata_i = 32'h1000_0000 | ICacheAddr_o;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] target);
    Redirect_i = 1'b1; RedirectPC_i = target;
    step();
    Redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ICacheStall_i = 1'b0; Stall_i = 1'b0; Redirect_i = 1'b0; RedirectPC_i = 32'h0;
    step(); step();
    rst_i = 1'b0;
    checks += 4;
    if (ICacheReq_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", ICacheReq_o); end
    if (Valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid_o); end
    if (Instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", Instr_o); end
    if (PCPlus4_o !== 32'h0) begin failures++; $display("FAIL reset_pcplus4 got=%h exp=00000000", PCPlus4_o); end
    $display("reset: req=%b valid=%b instr=%h", ICacheReq_o, Valid_o, Instr_o);
  endtask

  task automatic test_hits();
    logic [31:0] exp_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    step();
    checks += 2;
    if (ICacheReq_o !== 1'b1) begin failures++; $display("FAIL hit_req got=%b exp=1", ICacheReq_o); end
    if (ICacheAddr_o !== exp_addr[0]) begin failures++; $display("FAIL hit_addr0 got=%h exp=%h", ICacheAddr_o, exp_addr[0]); end
    for (int i = 1; i < 3; i++) begin
      step();
      checks += 4;
      if (ICacheAddr_o !== exp_addr[i]) begin failures++; $display("FAIL hit_addr%0d got=%h exp=%h", i, ICacheAddr_o, exp_addr[i]); end
      if (Instr_o !== (32'h1000_0000 | exp_addr[i-1])) begin failures++; $display("FAIL hit_instr%0d got=%h exp=%h", i, Instr_o, 32'h1000_0000 | exp_addr[i-1]); end
      if (PCPlus4_o !== exp_addr[i]) begin failures++; $display("FAIL hit_pcplus4_%0d got=%h exp=%h", i, PCPlus4_o, exp_addr[i]); end
      if (Valid_o !== 1'b1) begin failures++; $display("FAIL hit_valid%0d got=%b exp=1", i, Valid_o); end
      $display("hit: addr=%h instr=%h pc4=%h valid=%b", ICacheAddr_o, Instr_o, PCPlus4_o, Valid_o);
    end
  endtask

  task automatic test_stall();
    Stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks += 3;
      if (ICacheAddr_o !== 32'h8) begin failures++; $display("FAIL stall_addr got=%h exp=00000008", ICacheAddr_o); end
      if (Instr_o !== 32'h1000_0004) begin failures++; $display("FAIL stall_instr got=%h exp=10000004", Instr_o); end
      if (PCPlus4_o !== 32'h8) begin failures++; $display("FAIL stall_pcplus4 got=%h exp=00000008", PCPlus4_o); end
      $display("stall: addr=%h instr=%h pc4=%h", ICacheAddr_o, Instr_o, PCPlus4_o);
    end
    Stall_i = 1'b0;
    step();
    checks += 3;
    if (ICacheAddr_o !== 32'hC) begin failures++; $display("FAIL unstall_addr got=%h exp=0000000c", ICacheAddr_o); end
    if (Instr_o !== 32'h1000_0008) begin failures++; $display("FAIL unstall_instr got=%h exp=10000008", Instr_o); end
    if (PCPlus4_o !== 32'hC) begin failures++; $display("FAIL unstall_pcplus4 got=%h exp=0000000c", PCPlus4_o); end
    $display("release: addr=%h instr=%h pc4=%h", ICacheAddr_o, Instr_o, PCPlus4_o);
  endtask

  task automatic test_redirect();
    jump_to(32'h40);
    checks += 4;
    if (ICacheAddr_o !== 32'h40) begin failures++; $display("FAIL redir_addr got=%h exp=00000040", ICacheAddr_o); end
    if (Valid_o !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", Valid_o); end
    if (Instr_o !== 32'h0) begin failures++; $display("FAIL redir_instr got=%h exp=00000000", Instr_o); end
    if (PCPlus4_o !== 32'hC) begin failures++; $display("FAIL redir_pcplus4 got=%h exp=0000000c", PCPlus4_o); end
    $display("redirect: addr=%h valid=%b instr=%h", ICacheAddr_o, Valid_o, Instr_o);
    step();
    Stall_i = 1'b1;
    jump_to(32'h53);
    Stall_i = 1'b0;
    checks += 2;
    if (ICacheAddr_o !== 32'h50) begin failures++; $display("FAIL redir_stall_addr got=%h exp=00000050", ICacheAddr_o); end
    if (Valid_o !== 1'b0) begin failures++; $display("FAIL redir_stall_valid got=%b exp=0", Valid_o); end
    $display("redirect+stall: addr=%h valid=%b", ICacheAddr_o, Valid_o);
  endtask

  task automatic test_miss();
    jump_to(32'h20);
    ICacheStall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (ICacheAddr_o !== 32'h20) begin failures++; $display("FAIL miss_addr got=%h exp=00000020", ICacheAddr_o); end
      if (ICacheReq_o !== 1'b1) begin failures++; $display("FAIL miss_req got=%b exp=1", ICacheReq_o); end
      if (Valid_o !== 1'b0) begin failures++; $display("FAIL miss_valid got=%b exp=0", Valid_o); end
      $display("miss: addr=%h req=%b valid=%b", ICacheAddr_o, ICacheReq_o, Valid_o);
    end
    ICacheStall_i = 1'b0;
    step();
    checks += 5;
    if (Instr_o !== 32'h1000_0020) begin failures++; $display("FAIL miss_instr got=%h exp=10000020", Instr_o); end
    if (Valid_o !== 1'b1) begin failures++; $display("FAIL miss_done_valid got=%b exp=1", Valid_o); end
    if (ICacheAddr_o !== 32'h24) begin failures++; $display("FAIL miss_next_addr got=%h exp=00000024", ICacheAddr_o); end
    if (Opcode_o !== 6'h04) begin failures++; $display("FAIL opcode got=%h exp=04", Opcode_o); end
    if (Funct_o !== 6'h20) begin failures++; $display("FAIL funct got=%h exp=20", Funct_o); end
    $display("miss release: instr=%h op=%h fn=%h addr=%h", Instr_o, Opcode_o, Funct_o, ICacheAddr_o);
  endtask

  task automatic test_miss_redirect();
    jump_to(32'h20);
    ICacheStall_i = 1'b1;
    step();
    jump_to(32'h82);
    step();
    checks += 2;
    if (ICacheAddr_o !== 32'h20) begin failures++; $display("FAIL mredir_addr got=%h exp=00000020", ICacheAddr_o); end
    if (Valid_o !== 1'b0) begin failures++; $display("FAIL mredir_valid got=%b exp=0", Valid_o); end
    ICacheStall_i = 1'b0;
    step();
    checks += 3;
    if (ICacheAddr_o !== 32'h80) begin failures++; $display("FAIL mredir_target got=%h exp=00000080", ICacheAddr_o); end
    if (Valid_o !== 1'b0) begin failures++; $display("FAIL mredir_drop_valid got=%b exp=0", Valid_o); end
    if (Instr_o !== 32'h0) begin failures++; $display("FAIL mredir_drop_instr got=%h exp=00000000", Instr_o); end
    step();
    checks += 2;
    if (Instr_o !== 32'h1000_0080) begin failures++; $display("FAIL mredir_instr got=%h exp=10000080", Instr_o); end
    if (PCPlus4_o !== 32'h84) begin failures++; $display("FAIL mredir_pcplus4 got=%h exp=00000084", PCPlus4_o); end
    $display("miss redirect: instr=%h pc4=%h addr=%h", Instr_o, PCPlus4_o, ICacheAddr_o);
  endtask

  task automatic test_reset_miss_wrap();
    jump_to(32'h20);
    ICacheStall_i = 1'b1;
    step(); step();
    rst_i = 1'b1;
    step();
    checks += 3;
    if (ICacheReq_o !== 1'b0) begin failures++; $display("FAIL rstmiss_req got=%b exp=0", ICacheReq_o); end
    if (Valid_o !== 1'b0) begin failures++; $display("FAIL rstmiss_valid got=%b exp=0", Valid_o); end
    if (PCPlus4_o !== 32'h0) begin failures++; $display("FAIL rstmiss_pcplus4 got=%h exp=00000000", PCPlus4_o); end
    rst_i = 1'b0; ICacheStall_i = 1'b0;
    step();
    checks += 1;
    if (ICacheAddr_o !== 32'h0) begin failures++; $display("FAIL rstmiss_pc got=%h exp=00000000", ICacheAddr_o); end
    $display("reset mid-miss: req=%b addr=%h valid=%b", ICacheReq_o, ICacheAddr_o, Valid_o);
    jump_to(32'hFFFF_FFFC);
    step();
    checks += 4;
    if (Instr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_instr got=%h exp=fffffffc", Instr_o); end
    if (PCPlus4_o !== 32'h0) begin failures++; $display("FAIL wrap_pcplus4 got=%h exp=00000000", PCPlus4_o); end
    if (ICacheAddr_o !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=00000000", ICacheAddr_o); end
    if (Valid_o !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", Valid_o); end
    $display("wrap: instr=%h pc4=%h addr=%h", Instr_o, PCPlus4_o, ICacheAddr_o);
  endtask

  initial begin
    test_reset();
    test_hits();
    test_stall();
    test_redirect();
    test_miss();
    test_miss_redirect();
    test_reset_miss_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
